// File: rtl/dmem_mmio_if.sv
// Core-side data bus between the single-cycle core and dmem_mmio.
// readdata is combinational from addr; stores commit on the rising clock edge.
interface dmem_mmio_if;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output memwrite, output addr, output writedata, input  readdata);
  modport slave  (input  memwrite, input  addr, input  writedata, output readdata);
endinterface

// File: rtl/dmem_mmio.sv
// Data memory for the single-cycle core: word RAM plus an MMIO window holding an
// LED register and a 32-bit compare timer with a registered interrupt.
module dmem_mmio #(
  parameter int          RAM_WORDS = 64,
  parameter logic [15:0] MMIO_HI   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  dmem_mmio_if.slave  bus,
  output logic [7:0]  led,
  output logic        irq
);
  localparam int AW = $clog2(RAM_WORDS);

  localparam logic [15:0] OFF_LED    = 16'h0000;
  localparam logic [15:0] OFF_COUNT  = 16'h0004;
  localparam logic [15:0] OFF_CMP    = 16'h0008;
  localparam logic [15:0] OFF_CTRL   = 16'h000C;
  localparam logic [15:0] OFF_STATUS = 16'h0010;

  logic [31:0] mem_q [RAM_WORDS];

  logic [7:0]  led_q,   led_d;
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q,   cmp_d;
  logic [2:0]  ctrl_q,  ctrl_d;   // {irq_en, autoreload, en}
  logic        flag_q,  flag_d;
  logic        irq_q,   irq_d;

  logic          mmio;
  logic [15:0]   off;
  logic [AW-1:0] idx;
  logic          wr_led, wr_count, wr_cmp, wr_ctrl, wr_status;
  logic          match;

  always_comb begin
    mmio      = (bus.addr[31:16] == MMIO_HI);
    off       = bus.addr[15:0];
    idx       = bus.addr[AW+1:2];
    wr_led    = bus.memwrite & mmio & (off == OFF_LED);
    wr_count  = bus.memwrite & mmio & (off == OFF_COUNT);
    wr_cmp    = bus.memwrite & mmio & (off == OFF_CMP);
    wr_ctrl   = bus.memwrite & mmio & (off == OFF_CTRL);
    wr_status = bus.memwrite & mmio & (off == OFF_STATUS);
  end

  // RAM is never reset; a store still lands while the MMIO block is in reset.
  always_ff @(posedge clk) begin
    if (bus.memwrite && !mmio) mem_q[idx] <= bus.writedata;
  end

  always_comb begin
    led_d   = led_q;
    cmp_d   = cmp_q;
    ctrl_d  = ctrl_q;
    count_d = count_q;
    flag_d  = flag_q;
    match   = ctrl_q[0] & (count_q == cmp_q) & ~wr_count;

    if (wr_led)  led_d  = bus.writedata[7:0];
    if (wr_cmp)  cmp_d  = bus.writedata;
    if (wr_ctrl) ctrl_d = bus.writedata[2:0];

    if (wr_count)       count_d = bus.writedata;
    else if (match)     count_d = ctrl_q[1] ? 32'd0 : count_q + 32'd1;
    else if (ctrl_q[0]) count_d = count_q + 32'd1;

    // A fresh match overrides a same-cycle W1C so no event is lost.
    if (wr_status && bus.writedata[0]) flag_d = 1'b0;
    if (match)                         flag_d = 1'b1;

    irq_d = flag_d & ctrl_d[2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q   <= 8'h00;
      count_q <= 32'h0;
      cmp_q   <= 32'hFFFF_FFFF;
      ctrl_q  <= 3'b000;
      flag_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      led_q   <= led_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      ctrl_q  <= ctrl_d;
      flag_q  <= flag_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    bus.readdata = 32'h0;
    if (mmio) begin
      case (off)
        OFF_LED:    bus.readdata = {24'h0, led_q};
        OFF_COUNT:  bus.readdata = count_q;
        OFF_CMP:    bus.readdata = cmp_q;
        OFF_CTRL:   bus.readdata = {29'h0, ctrl_q};
        OFF_STATUS: bus.readdata = {31'h0, flag_q};
        default:    bus.readdata = 32'h0;
      endcase
    end else begin
      bus.readdata = mem_q[idx];
    end
  end

  assign led = led_q;
  assign irq = irq_q;
endmodule
